ram_sdp_sr_sw_be: RTL and testbench



---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_init_fsm.sv | 81 ++++++++
 rtl/ram_sdp_sr_sw_be.sv | 132 +++++++++++++
 tb/tb_ram_sdp_sr_sw_be.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enable RAM.
// Holds the init-engine state encoding, the read-during-write mode constants
// and the per-byte merge used for both array writes and new-data bypass.
package ram_pkg;

    typedef enum logic {
        RAM_INIT  = 1'b0,
        RAM_READY = 1'b1
    } ram_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Pick the new byte when its lane is enabled, otherwise keep the old one.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_init_fsm.sv
// Init engine for ram_sdp_sr_sw_be: walks a fill counter over every word after
// reset or on init_req, and muxes the array write port between the fill
// stream and the user write port.
module ram_init_fsm
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_req,
    input  logic                      wr_req,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    output logic                      init_busy,
    output logic                      arr_we,
    output logic [ADDR_WIDTH-1:0]     arr_addr,
    output logic [DATA_WIDTH-1:0]     arr_data,
    output logic [DATA_WIDTH/8-1:0]   arr_be
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    ram_state_t            state_reg;
    logic                  busy_reg;
    logic [ADDR_WIDTH-1:0] cnt_reg;

    // State, fill counter and registered busy flag; init_req only honoured in READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RAM_INIT;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                RAM_INIT: begin
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg <= RAM_READY;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RAM_READY: begin
                    if (init_req) begin
                        state_reg <= RAM_INIT;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= RAM_INIT;
                    busy_reg  <= 1'b1;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // While filling, the fill stream owns the array port with all lanes enabled.
    always_comb begin
        arr_we   = wr_req;
        arr_addr = wr_addr;
        arr_data = wr_data;
        arr_be   = wr_be;
        if (busy_reg) begin
            arr_we   = 1'b1;
            arr_addr = cnt_reg;
            arr_data = INIT_VALUE;
            arr_be   = '1;
        end
    end

    assign init_busy = busy_reg;

endmodule

// File: rtl/ram_sdp_sr_sw_be.sv
// Simple-dual-port synchronous RAM with byte-enable writes, registered reads,
// selectable read-during-write behaviour and a hardware fill engine.
// Optional: define RAM_OUT_REG_EN to add an output register stage (read
// latency 2 instead of 1; the read-during-write result is taken at stage 1).
module ram_sdp_sr_sw_be
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    RDW_MODE   = RDW_OLD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_req,
    output logic                      init_busy,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid
);

    localparam int                  BE_WIDTH  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_req;
    logic                  rd_accept;
    logic                  rdw_bypass;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_data;
    logic [BE_WIDTH-1:0]   arr_be;
    logic [DATA_WIDTH-1:0] rd_word_raw;
    logic [DATA_WIDTH-1:0] rd_word_next;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;

    // Accesses only count in READY and outside reset; out-of-range writes vanish.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
    assign wr_req      = wr_en && wr_in_range && !init_busy && !reset;
    assign rd_accept   = rd_en && !init_busy && !reset;
    assign rdw_bypass  = (RDW_MODE == RDW_NEW) && wr_req && (wr_addr == rd_addr);

    ram_init_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_init (
        .clk       (clk),
        .reset     (reset),
        .init_req  (init_req),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .init_busy (init_busy),
        .arr_we    (arr_we),
        .arr_addr  (arr_addr),
        .arr_data  (arr_data),
        .arr_be    (arr_be)
    );

    // Byte-lane array write shared by the fill engine and the user port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (arr_we && arr_be[i]) begin
                mem[arr_addr][i*8 +: 8] <= arr_data[i*8 +: 8];
            end
        end
    end

    assign rd_word_raw = mem[rd_addr];

    // New-data mode forwards enabled write lanes when both ports hit one word.
    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_rdw_lane
            assign rd_word_next[gi*8 +: 8] = byte_merge(rd_word_raw[gi*8 +: 8],
                                                        wr_data[gi*8 +: 8],
                                                        rdw_bypass && wr_be[gi]);
        end
    endgenerate

    // Array read register; data only moves on an accepted read, so it holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_data_reg <= rd_in_range ? rd_word_next : '0;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_valid_reg;

    // Extra output stage: delays data and valid together by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= rd_valid_reg;
            if (rd_valid_reg) begin
                out_data_reg <= rd_data_reg;
            end
        end
    end

    assign rd_data  = out_data_reg;
    assign rd_valid = out_valid_reg;
`else
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
`endif

endmodule

// File: tb/tb_ram_sdp_sr_sw_be.sv
// Bench for ram_sdp_sr_sw_be: two instances share one stimulus stream
// (depth 16 / old-data and depth 12 / new-data), each tracked by an
// abstract memory model and compared on every falling edge.
module tb_ram_sdp_sr_sw_be;

`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] INITV = 32'hA5A5A5A5;

    logic        clk;
    logic        reset, init_req, wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] wr_data;
    logic        busy_a, busy_b, valid_a, valid_b;
    logic [31:0] dout_a, dout_b;

    int checks = 0;
    int errors = 0;

    ram_sdp_sr_sw_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16),
                       .INIT_VALUE(INITV), .RDW_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .init_req(init_req), .init_busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dout_a), .rd_valid(valid_a));

    ram_sdp_sr_sw_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(12),
                       .INIT_VALUE(INITV), .RDW_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .init_req(init_req), .init_busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dout_b), .rd_valid(valid_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dep(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] get_data(input int k);
        return (k == 0) ? dout_a : dout_b;
    endfunction
    function automatic logic get_valid(input int k);
        return (k == 0) ? valid_a : valid_b;
    endfunction
    function automatic logic get_busy(input int k);
        return (k == 0) ? busy_a : busy_b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [2][16];
    int          busy_left [2];
    bit          pend_v [2];
    logic [31:0] pend_d [2];
    bit          exp_v [2];
    logic [31:0] exp_d [2];
    bit          model_ok = 0;

    task automatic model_step();
        bit          r_v;
        logic [31:0] r_d;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                busy_left[k] = dep(k);
                pend_v[k] = 0; pend_d[k] = '0;
                exp_v[k]  = 0; exp_d[k]  = '0;
                for (int a = 0; a < 16; a++) m_mem[k][a] = INITV;
            end else begin
                r_v = 0; r_d = '0;
                if (busy_left[k] > 0) begin
                    busy_left[k]--;
                end else begin
                    if (rd_en) begin
                        r_v = 1;
                        if (int'(rd_addr) < dep(k)) begin
                            r_d = m_mem[k][rd_addr];
                            if (k == 1 && wr_en && wr_addr == rd_addr)
                                r_d = merge(r_d, wr_data, wr_be);
                        end
                    end
                    if (wr_en && int'(wr_addr) < dep(k))
                        m_mem[k][wr_addr] = merge(m_mem[k][wr_addr], wr_data, wr_be);
                    if (init_req) begin
                        busy_left[k] = dep(k);
                        for (int a = 0; a < 16; a++) m_mem[k][a] = INITV;
                    end
                end
                if (LAT == 2) begin
                    exp_v[k] = pend_v[k];
                    if (pend_v[k]) exp_d[k] = pend_d[k];
                    pend_v[k] = r_v;
                    pend_d[k] = r_d;
                end else begin
                    exp_v[k] = r_v;
                    if (r_v) exp_d[k] = r_d;
                end
            end
        end
        model_ok = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare every output of both instances against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("cyc dut%0d busy", k), 32'(get_busy(k)), 32'(busy_left[k] > 0));
                    check($sformatf("cyc dut%0d valid", k), 32'(get_valid(k)), 32'(exp_v[k]));
                    check($sformatf("cyc dut%0d data", k), get_data(k), exp_d[k]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input bit re, input logic [3:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    // Call right after drive() issued a read; checks both instances and the model.
    task automatic expect_read(input string name, input logic [31:0] ea, input logic [31:0] eb);
        logic [31:0] e;
        if (LAT == 2) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) begin
            e = (k == 0) ? ea : eb;
            check($sformatf("%s dut%0d valid", name, k), 32'(get_valid(k)), 32'd1);
            check($sformatf("%s dut%0d data", name, k), get_data(k), e);
            check($sformatf("%s model%0d", name, k), exp_d[k], e);
        end
        $display("read %s: a=%h b=%h", name, dout_a, dout_b);
    endtask

    task automatic measure_busy(output int na, output int nb);
        na = int'(busy_a);
        nb = int'(busy_b);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            init_req = 0;
            if (busy_a && busy_b) begin
                wr_en = 1; wr_addr = 4'd5; wr_data = 32'h0; wr_be = 4'hF;
                rd_en = 1; rd_addr = 4'd5;
            end else begin
                wr_en = 0; rd_en = 0;
            end
            if (!busy_a && !busy_b) break;
            na += int'(busy_a);
            nb += int'(busy_b);
        end
        wr_en = 0; rd_en = 0;
        $display("busy window: a=%0d b=%0d cycles", na, nb);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          na, nb, first_idx, last_idx;
        logic [31:0] got [$];
        logic [31:0] b2b_exp [4];

        reset = 1; init_req = 0; wr_en = 0; rd_en = 0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy_a", 32'(busy_a), 32'd1);
        check("reset valid_a", 32'(valid_a), 32'd0);
        check("reset data_a", dout_a, 32'd0);
        check("reset busy_b", 32'(busy_b), 32'd1);
        check("reset data_b", dout_b, 32'd0);

        reset = 0;
        measure_busy(na, nb);
        check("init busy len a", 32'(na), 32'd16);
        check("init busy len b", 32'(nb), 32'd12);

        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 0, 1, 4'(a));
            expect_read($sformatf("init addr%0d", a), INITV, (a < 12) ? INITV : 32'h0);
        end

        drive(1, 4'd3, 32'h11223344, 4'b1111, 0, 0);
        drive(1, 4'd3, 32'hFFFFFFFF, 4'b0101, 0, 0);
        drive(0, 0, 0, 0, 1, 4'd3);
        expect_read("be merge", 32'h11FF33FF, 32'h11FF33FF);

        drive(1, 4'd7, 32'h0, 4'b1111, 0, 0);
        drive(1, 4'd7, 32'hDEADBEEF, 4'b1111, 1, 4'd7);
        expect_read("rdw same", 32'h0, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 1, 4'd7);
        expect_read("rdw after", 32'hDEADBEEF, 32'hDEADBEEF);

        b2b_exp = '{INITV, INITV, INITV, 32'h11FF33FF};
        first_idx = -1; last_idx = -1;
        for (int j = 0; j < 6; j++) begin
            rd_en = (j < 4); rd_addr = 4'(j);
            @(posedge clk); #1;
            if (valid_a) begin
                got.push_back(dout_a);
                if (first_idx < 0) first_idx = j;
                last_idx = j;
            end
        end
        rd_en = 0;
        check("b2b count", 32'(got.size()), 32'd4);
        check("b2b first", 32'(first_idx), 32'(LAT - 1));
        check("b2b last", 32'(last_idx), 32'(LAT + 2));
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b data%0d", i), (i < got.size()) ? got[i] : 32'hX, b2b_exp[i]);
        $display("b2b reads: %0d results from cycle %0d", got.size(), first_idx);

        drive(1, 4'd5, 32'h12345678, 4'b1111, 0, 0);
        drive(0, 0, 0, 0, 1, 4'd5);
        expect_read("pre init_req", 32'h12345678, 32'h12345678);
        init_req = 1;
        measure_busy(na, nb);
        check("req busy len a", 32'(na), 32'd16);
        check("req busy len b", 32'(nb), 32'd12);
        drive(0, 0, 0, 0, 1, 4'd5);
        expect_read("post init_req", INITV, INITV);

        rd_en = 1; rd_addr = 4'd0;
        @(posedge clk); #1;
        rd_en = 0; reset = 1;
        @(posedge clk); #1;
        check("flush valid_a", 32'(valid_a), 32'd0);
        check("flush valid_b", 32'(valid_b), 32'd0);
        reset = 0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        measure_busy(na, nb);
        check("restart busy len a", 32'(na), 32'd16);
        check("restart busy len b", 32'(nb), 32'd12);

        drive(1, 4'd14, 32'hCAFEF00D, 4'b1111, 0, 0);
        drive(0, 0, 0, 0, 1, 4'd14);
        expect_read("oob addr14", 32'hCAFEF00D, 32'h0);

        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            init_req = ($urandom_range(0, 79) == 0);
            wr_en    = 1'($urandom);
            rd_en    = 1'($urandom);
            wr_addr  = 4'($urandom_range(0, 15));
            rd_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            wr_be    = 4'($urandom);
            wr_data  = $urandom;
            @(posedge clk); #1;
        end
        reset = 0; init_req = 0; wr_en = 0; rd_en = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
